conv_col_feeder: RTL

Streaming line-buffer stage that sits directly upstream of the multi-channel 5x5 convolution block. It accepts one pixel per cycle, all CHANNEL channel values together, in raster order. It emits one KERNEL_SIZE-tall column per channel per accepted pixel, packed exactly as the convolution block's `input_feature` bus and qualified by its `en` strobe. A small frame FSM gates acceptance and reports window validity and frame completion.

---
 rtl/conv_pkg.sv | 23 ++
 rtl/conv_col_feeder_if.sv | 32 +++
 rtl/line_row_buf.sv | 28 ++
 rtl/conv_col_feeder.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and default LeNet constants for the convolution datapath blocks
// (column feeder, 5x5 convolution, channel adder).
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } feeder_state_e;

  localparam int LENET_BIT_WIDTH       = 8;
  localparam int LENET_KERNEL_SIZE     = 5;
  localparam int LENET_CONV1_IMG_WIDTH = 32;
  localparam int LENET_CONV2_IMG_WIDTH = 14;
  localparam int LENET_CHANNEL         = 6;

  // Counter/address width for a range of 'depth' values, never narrower than one bit.
  function automatic int cnt_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/conv_col_feeder_if.sv
// Pixel-in / column-out bundle of the convolution column feeder.
// master = pixel source and column sink, slave = the feeder itself.
interface conv_col_feeder_if
  import conv_pkg::*;
#(
  parameter int BIT_WIDTH   = LENET_BIT_WIDTH,
  parameter int KERNEL_SIZE = LENET_KERNEL_SIZE,
  parameter int CHANNEL     = LENET_CHANNEL
);

  logic                                    frame_start;
  logic [BIT_WIDTH*CHANNEL-1:0]            pix_in;
  logic                                    pix_valid;
  logic                                    pix_ready;
  logic [BIT_WIDTH*KERNEL_SIZE*CHANNEL-1:0] col_out;
  logic                                    col_en;
  logic                                    win_valid;
  logic                                    row_last;
  logic                                    frame_done;
  logic                                    busy;

  modport master (
    output frame_start, pix_in, pix_valid,
    input  pix_ready, col_out, col_en, win_valid, row_last, frame_done, busy
  );

  modport slave (
    input  frame_start, pix_in, pix_valid,
    output pix_ready, col_out, col_en, win_valid, row_last, frame_done, busy
  );

endinterface

// File: rtl/line_row_buf.sv
// One image row of storage. Asynchronous read and synchronous write at the same
// address give read-before-write behaviour within a cycle.
module line_row_buf
  import conv_pkg::*;
#(
  parameter int DEPTH = LENET_CONV2_IMG_WIDTH,
  parameter int WIDTH = LENET_BIT_WIDTH * LENET_CHANNEL,
  localparam int AW   = cnt_bits(DEPTH)
) (
  input  logic             clk,
  input  logic [AW-1:0]    addr,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  assign rdata = mem_r[addr];

  // Row storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

endmodule

// File: rtl/conv_col_feeder.sv
// Line-buffer stage feeding KERNEL_SIZE-tall per-channel columns to the 5x5
// convolution block, with a frame FSM controlling acceptance and completion.
module conv_col_feeder
  import conv_pkg::*;
#(
  parameter int BIT_WIDTH   = LENET_BIT_WIDTH,
  parameter int KERNEL_SIZE = LENET_KERNEL_SIZE,
  parameter int CHANNEL     = LENET_CHANNEL,
  parameter int IMG_WIDTH   = LENET_CONV2_IMG_WIDTH,
  parameter int IMG_HEIGHT  = LENET_CONV2_IMG_WIDTH
) (
  input logic               clk,
  input logic               rst,
  conv_col_feeder_if.slave  bus
);

  localparam int PW = BIT_WIDTH * CHANNEL;
  localparam int CW = PW * KERNEL_SIZE;
  localparam int XW = cnt_bits(IMG_WIDTH);
  localparam int YW = cnt_bits(IMG_HEIGHT);

  localparam logic [XW-1:0] X_LAST      = XW'(IMG_WIDTH - 1);
  localparam logic [XW-1:0] X_WIN       = XW'(KERNEL_SIZE - 1);
  localparam logic [XW-1:0] X_ONE       = XW'(1);
  localparam logic [YW-1:0] Y_FILL_LAST = YW'(KERNEL_SIZE - 2);
  localparam logic [YW-1:0] Y_LAST      = YW'(IMG_HEIGHT - 1);
  localparam logic [YW-1:0] Y_ONE       = YW'(1);

  feeder_state_e  state_r;
  logic [XW-1:0]  x_r;
  logic [YW-1:0]  y_r;
  logic           pix_ready_r;
  logic           busy_r;
  logic           frame_done_r;
  logic           col_en_r;
  logic           win_valid_r;
  logic           row_last_r;
  logic [CW-1:0]  col_out_r;

  logic           accept_s;
  logic [PW-1:0]  rd_s   [KERNEL_SIZE-1];
  logic [PW-1:0]  rows_s [KERNEL_SIZE];
  logic [CW-1:0]  col_s;

  assign accept_s = bus.pix_valid & pix_ready_r;

  // Row k shifts up from row k+1; the newest row is fed from the incoming pixel.
  assign rows_s[KERNEL_SIZE-1] = bus.pix_in;

  for (genvar k = 0; k < KERNEL_SIZE - 1; k++) begin : g_row
    assign rows_s[k] = rd_s[k];

    line_row_buf #(
      .DEPTH (IMG_WIDTH),
      .WIDTH (PW)
    ) u_row (
      .clk   (clk),
      .addr  (x_r),
      .we    (accept_s),
      .wdata (rows_s[k+1]),
      .rdata (rd_s[k])
    );
  end

  // Re-pack row-major pixels into the channel-major convolution input bus.
  always_comb begin
    col_s = '0;
    for (int c = 0; c < CHANNEL; c++) begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        col_s[(c*KERNEL_SIZE + r)*BIT_WIDTH +: BIT_WIDTH] = rows_s[r][c*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

  // Frame FSM, raster counters and registered column outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      x_r          <= '0;
      y_r          <= '0;
      pix_ready_r  <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      col_en_r     <= 1'b0;
      win_valid_r  <= 1'b0;
      row_last_r   <= 1'b0;
      col_out_r    <= '0;
    end else begin
      frame_done_r <= 1'b0;
      col_en_r     <= 1'b0;
      win_valid_r  <= 1'b0;
      row_last_r   <= 1'b0;

      case (state_r)
        IDLE: begin
          if (bus.frame_start) begin
            state_r     <= FILL;
            x_r         <= '0;
            y_r         <= '0;
            pix_ready_r <= 1'b1;
            busy_r      <= 1'b1;
          end
        end
        FILL: begin
          if (accept_s && (x_r == X_LAST) && (y_r == Y_FILL_LAST)) begin
            state_r <= STREAM;
          end
        end
        STREAM: begin
          if (accept_s && (x_r == X_LAST) && (y_r == Y_LAST)) begin
            state_r      <= DONE;
            pix_ready_r  <= 1'b0;
            frame_done_r <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          pix_ready_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase

      if (accept_s) begin
        if (x_r == X_LAST) begin
          x_r <= '0;
          y_r <= (y_r == Y_LAST) ? '0 : (y_r + Y_ONE);
        end else begin
          x_r <= x_r + X_ONE;
        end
      end

      // Only STREAM accepts have KERNEL_SIZE-1 valid rows above them.
      if (accept_s && (state_r == STREAM)) begin
        col_en_r    <= 1'b1;
        col_out_r   <= col_s;
        win_valid_r <= (x_r >= X_WIN);
        row_last_r  <= (x_r == X_LAST);
      end
    end
  end

  assign bus.pix_ready  = pix_ready_r;
  assign bus.busy       = busy_r;
  assign bus.frame_done = frame_done_r;
  assign bus.col_en     = col_en_r;
  assign bus.win_valid  = win_valid_r;
  assign bus.row_last   = row_last_r;
  assign bus.col_out    = col_out_r;

endmodule
